// File: rtl/gpio_pkg.sv
// Shared definitions for the GPIO lite register port: register map and the
// access-arbiter FSM encoding.
package gpio_pkg;

  localparam logic [5:0] DIRECTION_MODE = 6'h04;
  localparam logic [5:0] OUTPUT_ENABLE  = 6'h08;
  localparam logic [5:0] OUTPUT_VALUE   = 6'h0C;
  localparam logic [5:0] INPUT_VALUE    = 6'h10;
  localparam logic [5:0] INT_STATUS     = 6'h20;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StIssue   = 2'd1,
    StCapture = 2'd2,
    StResp    = 2'd3
  } gpio_state_e;

endpackage

// File: rtl/gpio_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after rr_ptr wins,
// wrapping modulo NUM_REQ.
module gpio_rr_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned IdxW    = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IdxW-1:0]    rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IdxW-1:0]    winner
);

  localparam int unsigned SumW = IdxW + 1;

  logic [SumW-1:0] sum;
  logic [IdxW-1:0] idx;
  logic            found;

  always_comb begin
    grant  = '0;
    winner = '0;
    found  = 1'b0;
    sum    = '0;
    idx    = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, rr_ptr} + SumW'(k);
      if (sum >= SumW'(NUM_REQ)) begin
        sum = sum - SumW'(NUM_REQ);
      end
      idx = sum[IdxW-1:0];
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        winner     = idx;
      end
    end
  end

endmodule

// File: rtl/gpio_access_arbiter.sv
// Shares one GPIO lite register port between NUM_REQ requesters with a
// round-robin grant and a single transaction in flight.
module gpio_access_arbiter
  import gpio_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned AW      = 6,
  parameter int unsigned DW      = 16
) (
  input  logic                  pclk,
  input  logic                  n_reset,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ-1:0]    req_write,
  input  logic [NUM_REQ*AW-1:0] req_addr,
  input  logic [NUM_REQ*DW-1:0] req_wdata,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic [NUM_REQ-1:0]    rsp_valid,
  output logic [DW-1:0]         rsp_rdata,
  input  logic [NUM_REQ-1:0]    rsp_ready,
  output logic                  read,
  output logic                  write,
  output logic [AW-1:0]         addr,
  output logic [DW-1:0]         wdata,
  input  logic [DW-1:0]         rdata
);

  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  gpio_state_e     state_q, state_d;
  logic [IdxW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IdxW-1:0] winner_q, winner_d;
  logic            cmd_write_q, cmd_write_d;
  logic [AW-1:0]   cmd_addr_q, cmd_addr_d;
  logic [DW-1:0]   cmd_wdata_q, cmd_wdata_d;
  logic [DW-1:0]   rsp_rdata_q, rsp_rdata_d;

  logic [NUM_REQ-1:0] arb_grant;
  logic [IdxW-1:0]    arb_winner;

  gpio_rr_arbiter #(
    .NUM_REQ(NUM_REQ),
    .IdxW   (IdxW)
  ) u_rr_arbiter (
    .req   (req_valid),
    .rr_ptr(rr_ptr_q),
    .grant (arb_grant),
    .winner(arb_winner)
  );

  always_ff @(posedge pclk) begin
    if (!n_reset) begin
      state_q     <= StIdle;
      rr_ptr_q    <= '0;
      winner_q    <= '0;
      cmd_write_q <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      winner_q    <= winner_d;
      cmd_write_q <= cmd_write_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_wdata_q <= cmd_wdata_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    winner_d    = winner_q;
    cmd_write_d = cmd_write_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_wdata_d = cmd_wdata_q;
    rsp_rdata_d = rsp_rdata_q;
    req_ready   = '0;
    rsp_valid   = '0;
    rsp_rdata   = '0;
    read        = 1'b0;
    write       = 1'b0;
    addr        = '0;
    wdata       = '0;

    unique case (state_q)
      StIdle: begin
        if (|req_valid) begin
          req_ready   = arb_grant;
          winner_d    = arb_winner;
          cmd_write_d = req_write[arb_winner];
          cmd_addr_d  = req_addr[arb_winner*AW +: AW];
          cmd_wdata_d = req_wdata[arb_winner*DW +: DW];
          rr_ptr_d    = (arb_winner == IdxW'(NUM_REQ - 1)) ? '0 : arb_winner + 1'b1;
          state_d     = StIssue;
        end
      end
      StIssue: begin
        read  = !cmd_write_q;
        write = cmd_write_q;
        addr  = cmd_addr_q;
        wdata = cmd_wdata_q;
        if (cmd_write_q) begin
          // Write acks carry zero data.
          rsp_rdata_d = '0;
          state_d     = StResp;
        end else begin
          state_d = StCapture;
        end
      end
      StCapture: begin
        // Subunit read data is registered: valid one cycle after the strobe.
        rsp_rdata_d = rdata;
        state_d     = StResp;
      end
      StResp: begin
        rsp_valid[winner_q] = 1'b1;
        rsp_rdata           = rsp_rdata_q;
        if (rsp_ready[winner_q]) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_gpio_access_arbiter.sv
// Self-checking bench for gpio_access_arbiter with a clear-on-read GPIO subunit model.
module tb_gpio_access_arbiter;

  logic        pclk = 1'b0;
  logic        n_reset;
  logic [1:0]  req_valid, req_write, req_ready, rsp_valid, rsp_ready;
  logic [11:0] req_addr;
  logic [31:0] req_wdata;
  logic [15:0] rsp_rdata, wdata;
  logic        read, write;
  logic [5:0]  addr;
  logic [15:0] rdata = '0;

  gpio_access_arbiter #(
    .NUM_REQ(2),
    .AW     (6),
    .DW     (16)
  ) dut (
    .pclk     (pclk),
    .n_reset  (n_reset),
    .req_valid(req_valid),
    .req_write(req_write),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_ready(rsp_ready),
    .read     (read),
    .write    (write),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata)
  );

  always #5 pclk = ~pclk;

  // Subunit model: plain register file plus a clear-on-read status register.
  logic [15:0] mem [64] = '{default: 16'h0};
  logic [15:0] int_status = '0;
  logic [15:0] int_set = '0;

  always @(posedge pclk) begin
    if (write) mem[addr] <= wdata;
    if (read) rdata <= (addr == 6'h20) ? int_status : mem[addr];
    if (read && addr == 6'h20) int_status <= int_set;
    else int_status <= int_status | int_set;
  end

  int strobe_cnt = 0, int_reads = 0, dual_cnt = 0;
  always @(posedge pclk) begin
    if (read || write) strobe_cnt <= strobe_cnt + 1;
    if (read && addr == 6'h20) int_reads <= int_reads + 1;
    if (req_ready == 2'b11) dual_cnt <= dual_cnt + 1;
  end

  int n_pass = 0, n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic idle_cycle();
    @(negedge pclk);
    rsp_ready = '0;
    req_valid = '0;
    #1;
  endtask

  // One transaction from an IDLE start: present commands, record the grant,
  // follow strobe and response, then handshake after `hold` stall cycles.
  task automatic txn(input logic [1:0] mask, input logic [1:0] wr, input logic [11:0] ad,
                     input logic [31:0] wd, input int hold,
                     output int win, output logic [15:0] rd, output int lat);
    int c;
    logic [15:0] held;
    @(negedge pclk);
    rsp_ready = '0;
    req_valid = mask;
    req_write = wr;
    req_addr  = ad;
    req_wdata = wd;
    #1;
    c = 0;
    while (req_ready == '0 && c < 10) begin
      @(negedge pclk);
      #1;
      c++;
    end
    check("grant_wait", c, 0);
    if (req_ready == '0) begin
      req_valid = '0;
      win = -1;
      rd = '0;
      lat = 0;
      return;
    end
    win = req_ready[1] ? 1 : 0;
    check("grant_onehot", req_ready, 2'b01 << win);
    @(negedge pclk);
    req_valid = '0;
    #1;
    lat = 1;
    check("strobe_write", write, wr[win]);
    check("strobe_read", read, !wr[win]);
    check("strobe_addr", addr, ad[win*6 +: 6]);
    if (wr[win]) check("strobe_wdata", wdata, wd[win*16 +: 16]);
    do begin
      @(negedge pclk);
      #1;
      lat++;
    end while (rsp_valid == '0 && lat < 8);
    check("rsp_onehot", rsp_valid, 2'b01 << win);
    rd = rsp_rdata;
    held = rsp_rdata;
    repeat (hold) begin
      @(negedge pclk);
      #1;
      check("rsp_hold_valid", rsp_valid, 2'b01 << win);
      check("rsp_hold_data", rsp_rdata, held);
    end
    @(negedge pclk);
    rsp_ready = 2'b01 << win;
    #1;
  endtask

  typedef struct {
    int          req;
    logic        wr;
    logic [5:0]  a;
    logic [15:0] d;
    logic [15:0] exp;
  } vec_t;

  vec_t        tbl[8];
  logic [15:0] m_mem [64];
  int          m_ptr;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int win, lat, s, c, ng, ew;
    int got[6];
    int snap[6];
    logic [15:0] rd, rd1, exp_rd;
    logic [1:0] drop, mask, wr;
    bit got0, got1;
    logic [5:0] pool[8];
    logic [5:0] a0, a1;

    tbl[0] = '{0, 1'b1, 6'h04, 16'h1111, 16'h0000};
    tbl[1] = '{1, 1'b0, 6'h04, 16'h0000, 16'h1111};
    tbl[2] = '{1, 1'b1, 6'h0C, 16'hBEEF, 16'h0000};
    tbl[3] = '{0, 1'b0, 6'h0C, 16'h0000, 16'hBEEF};
    tbl[4] = '{0, 1'b0, 6'h30, 16'h0000, 16'h0000};
    tbl[5] = '{1, 1'b1, 6'h3F, 16'hFFFF, 16'h0000};
    tbl[6] = '{1, 1'b0, 6'h3F, 16'h0000, 16'hFFFF};
    tbl[7] = '{0, 1'b0, 6'h10, 16'h0000, 16'h1234};
    pool = '{6'h04, 6'h08, 6'h0C, 6'h10, 6'h14, 6'h18, 6'h30, 6'h3C};

    n_reset = 1'b0;
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0; rsp_ready = '0;
    repeat (3) @(negedge pclk);
    #1;
    check("reset_outputs", {req_ready, rsp_valid, read, write, addr, wdata, rsp_rdata}, 0);

    // Reset while a read is in ISSUE: the read is dropped, rr_ptr returns to 0.
    @(negedge pclk);
    n_reset = 1'b1;
    req_valid = 2'b01; req_write = 2'b00; req_addr = {6'h00, 6'h10};
    #1;
    check("rst_grant", req_ready, 2'b01);
    @(negedge pclk);
    req_valid = '0;
    n_reset = 1'b0;
    #1;
    check("rst_issue_read", read, 1);
    repeat (2) @(negedge pclk);
    n_reset = 1'b1;
    #1;
    check("rst_after_outputs", {req_ready, rsp_valid, read, write}, 0);
    s = strobe_cnt;
    repeat (4) @(negedge pclk);
    #1;
    check("rst_no_strobe", strobe_cnt, s);
    check("rst_no_rsp", rsp_valid, 0);

    // Contention: both continuously valid; first grant 0 also proves rr_ptr=0.
    @(negedge pclk);
    req_valid = 2'b11; req_write = 2'b11;
    req_addr = {6'h0C, 6'h04}; req_wdata = {16'h2222, 16'h1111};
    rsp_ready = 2'b11;
    ng = 0; c = 0;
    while (ng < 6 && c < 60) begin
      #1;
      if (req_ready != '0) begin
        got[ng] = req_ready[1] ? 1 : 0;
        snap[ng] = strobe_cnt;
        ng++;
      end
      @(negedge pclk);
      c++;
    end
    req_valid = '0;
    check("cont_grants", ng, 6);
    for (int k = 0; k < ng; k++) check($sformatf("cont_order_%0d", k), got[k], k % 2);
    for (int k = 0; k + 1 < ng; k++)
      check($sformatf("cont_strobes_%0d", k), snap[k+1] - snap[k], 1);
    repeat (3) @(negedge pclk);
    #1;
    if (ng > 0) check("cont_total_strobes", strobe_cnt - snap[0], 6);

    // Single write.
    s = strobe_cnt;
    txn(2'b01, 2'b01, {6'h00, 6'h08}, {16'h0, 16'hA5A5}, 0, win, rd, lat);
    check("wr_win", win, 0);
    check("wr_lat", lat, 2);
    check("wr_rdata", rd, 0);
    idle_cycle();
    check("wr_rsp_drop", rsp_valid, 0);
    check("wr_one_strobe", strobe_cnt - s, 1);

    // Single read of 16'h1234, stalled 5 cycles.
    txn(2'b01, 2'b01, {6'h00, 6'h10}, {16'h0, 16'h1234}, 0, win, rd, lat);
    txn(2'b01, 2'b00, {6'h00, 6'h10}, 32'h0, 5, win, rd, lat);
    check("rd_lat", lat, 3);
    check("rd_rdata", rd, 16'h1234);
    idle_cycle();
    check("rd_rsp_drop", rsp_valid, 0);

    // Clear-on-read safety.
    @(negedge pclk);
    int_set = 16'h0081;
    @(negedge pclk);
    int_set = 16'h0;
    req_valid = 2'b11; req_write = 2'b01;
    req_addr = {6'h20, 6'h04}; req_wdata = {16'h0, 16'h5A5A};
    rsp_ready = 2'b11;
    drop = '0; got0 = 0; got1 = 0; rd1 = '0; c = 0;
    while (!(got0 && got1) && c < 30) begin
      req_valid = req_valid & ~drop;
      #1;
      drop = req_ready;
      if (rsp_valid[1]) begin rd1 = rsp_rdata; got1 = 1; end
      if (rsp_valid[0]) begin check("cor_write_ack", rsp_rdata, 0); got0 = 1; end
      @(negedge pclk);
      c++;
    end
    req_valid = '0;
    rsp_ready = '0;
    check("cor_both_done", {got1, got0}, 2'b11);
    check("cor_status", rd1, 16'h0081);
    repeat (3) @(negedge pclk);
    #1;
    check("cor_single_read", int_reads, 1);

    // Withdraw: req1 appears during req0's RESP and leaves before IDLE.
    @(negedge pclk);
    req_valid = 2'b01; req_write = 2'b01;
    req_addr = {6'h08, 6'h0C}; req_wdata = {16'h0, 16'h1357};
    #1;
    check("wd_grant", req_ready, 2'b01);
    @(negedge pclk);
    req_valid = '0;
    @(negedge pclk);
    req_valid = 2'b10; req_write = 2'b01;
    #1;
    check("wd_resp", rsp_valid, 2'b01);
    check("wd_no_ready_resp", req_ready, 0);
    s = strobe_cnt;
    @(negedge pclk);
    req_valid = '0;
    rsp_ready = 2'b01;
    for (int k = 0; k < 4; k++) begin
      @(negedge pclk);
      rsp_ready = '0;
      #1;
      check("wd_no_grant", req_ready, 0);
    end
    check("wd_no_strobe", strobe_cnt, s);

    // Table-driven transactions.
    foreach (tbl[i]) begin
      txn(2'(1 << tbl[i].req), {2{tbl[i].wr}}, {2{tbl[i].a}}, {2{tbl[i].d}}, i % 3,
          win, rd, lat);
      check($sformatf("tbl_win_%0d", i), win, tbl[i].req);
      check($sformatf("tbl_lat_%0d", i), lat, tbl[i].wr ? 2 : 3);
      check($sformatf("tbl_rdata_%0d", i), rd, tbl[i].exp);
    end

    // Randomized rounds against a transaction-level model.
    m_ptr = (tbl[7].req + 1) % 2;
    for (int r = 0; r < 48; r++) begin
      if (r < 8) begin
        mask = 2'(1 << (r % 2)); wr = 2'b11; a0 = pool[r]; a1 = pool[r];
      end else begin
        mask = 2'($urandom_range(1, 3)); wr = 2'($urandom_range(0, 3));
        a0 = pool[$urandom_range(0, 7)]; a1 = pool[$urandom_range(0, 7)];
      end
      ew = -1;
      for (int k = 0; k < 2; k++)
        if (ew < 0 && mask[(m_ptr + k) % 2]) ew = (m_ptr + k) % 2;
      rd1 = 16'($urandom);
      exp_rd = 16'($urandom);
      txn(mask, wr, {a1, a0}, {rd1, exp_rd}, $urandom_range(0, 3), win, rd, lat);
      check("rand_win", win, ew);
      check("rand_lat", lat, wr[ew] ? 2 : 3);
      if (wr[ew]) begin
        check("rand_wack", rd, 0);
        m_mem[ew ? a1 : a0] = ew ? rd1 : exp_rd;
      end else begin
        check("rand_rdata", rd, m_mem[ew ? a1 : a0]);
      end
      m_ptr = (ew + 1) % 2;
    end

    idle_cycle();
    check("never_dual_ready", dual_cnt, 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
